// File: rtl/debounce_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge_detect
// Description : Debouncer for an input level already synchronised into the
//               clk domain by a two-flop synchronizer. A new level is
//               accepted only after d_sync has held it for STABLE_CYCLES
//               consecutive clock edges. The block produces a clean level,
//               single-cycle rise/fall pulses and a wrapping count of
//               accepted rising transitions (presses).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STABLE_CYCLES : edges a new value must persist before acceptance
//                   (legal range 2 .. 2**CNT_W-1)
//   CNT_W         : width of the internal stability counter
//   PCNT_W        : width of press_count
// Ports
//   clk         in   1       system clock, all state updates on posedge
//   rst_n       in   1       synchronous active-low reset
//   d_sync      in   1       synchronised raw input
//   clr         in   1       synchronous clear of press_count
//   level       out  1       debounced level (registered)
//   rise        out  1       one-cycle pulse when level goes 0->1
//   fall        out  1       one-cycle pulse when level goes 1->0
//   press_count out  PCNT_W  wrapping count of accepted rising transitions
// ============================================================================
module debounce_edge_detect #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int PCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_sync,
  input  logic              clr,
  output logic              level,
  output logic              rise,
  output logic              fall,
  output logic [PCNT_W-1:0] press_count
);

  // Counter value seen on the edge that completes a stable run. The first
  // differing edge moves the FSM into WAIT_* with cnt=1, so the N-th
  // consecutive edge finds cnt == N-1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                level_q;
  logic                level_d;
  logic                rise_q;
  logic                rise_d;
  logic                fall_q;
  logic                fall_d;
  logic [PCNT_W-1:0]   pcnt_q;
  logic [PCNT_W-1:0]   pcnt_d;

  // --------------------------------------------------------------------------
  // State and output registers. Reset takes priority over every input,
  // including clr, and discards any partially accumulated stability count.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Pulses default low so they can only
  // last one cycle; level and press count hold unless explicitly updated.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pcnt_d  = pcnt_q;

    case (state_q)
      STABLE_LO: begin
        if (d_sync) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_HI: begin
        if (!d_sync) begin
          // Glitch: fall back without touching the outputs.
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          pcnt_d  = pcnt_q + PCNT_W'(1);  // wraps naturally at 2**PCNT_W
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      STABLE_HI: begin
        if (!d_sync) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_LO: begin
        if (d_sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase

    // Clear wins over a simultaneous accepted rise; the rise pulse itself
    // is unaffected.
    if (clr) begin
      pcnt_d = '0;
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign press_count = pcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_edge_detect
// Description : Self-checking bench for debounce_edge_detect with
//               STABLE_CYCLES=4, PCNT_W=8. A run-length reference model is
//               compared against the DUT every cycle; directed sequences add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_edge_detect;

  localparam int N      = 4;
  localparam int CNT_W  = 16;
  localparam int PCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              d_sync = 1'b0;
  logic              clr = 1'b0;
  logic              level;
  logic              rise;
  logic              fall;
  logic [PCNT_W-1:0] press_count;

  int tests = 0;
  int fails = 0;

  debounce_edge_detect #(
    .STABLE_CYCLES(N),
    .CNT_W        (CNT_W),
    .PCNT_W       (PCNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_sync     (d_sync),
    .clr        (clr),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: the accepted level flips once the input has differed
  // from it on N consecutive edges; any edge that agrees restarts the run.
  // --------------------------------------------------------------------------
  logic        m_level = 1'b0;
  logic        m_rise  = 1'b0;
  logic        m_fall  = 1'b0;
  int          m_run   = 0;
  int          m_pc    = 0;
  bit          m_valid = 1'b0;
  int          m_next_run;
  logic        m_flip;

  assign m_next_run = (d_sync != m_level) ? m_run + 1 : 0;
  assign m_flip     = (m_next_run == N);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_level <= 1'b0;
      m_rise  <= 1'b0;
      m_fall  <= 1'b0;
      m_run   <= 0;
      m_pc    <= 0;
      m_valid <= 1'b1;
    end else begin
      m_rise  <= m_flip && !m_level;
      m_fall  <= m_flip && m_level;
      m_level <= m_flip ? ~m_level : m_level;
      m_run   <= m_flip ? 0 : m_next_run;
      if (clr)
        m_pc <= 0;
      else if (m_flip && !m_level)
        m_pc <= (m_pc + 1) % (1 << PCNT_W);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_level", 32'(level), 32'(m_level));
      check("cyc_rise",  32'(rise),  32'(m_rise));
      check("cyc_fall",  32'(fall),  32'(m_fall));
      check("cyc_pcnt",  32'(press_count), 32'(m_pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One clean press: accepted rise followed by accepted fall.
  task automatic press();
    d_sync = 1'b1;
    ticks(N);
    d_sync = 1'b0;
    ticks(N);
  endtask

  initial begin
    // ---- 1: reset, then held high -----------------------------------------
    rst_n = 1'b0; d_sync = 1'b0; clr = 1'b1;
    tick();
    check("rst_level", 32'(level), 0);
    check("rst_rise",  32'(rise),  0);
    check("rst_fall",  32'(fall),  0);
    check("rst_pcnt",  32'(press_count), 0);
    rst_n = 1'b1; clr = 1'b0; d_sync = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("t1_level_pre", 32'(level), 0);
      check("t1_rise_pre",  32'(rise),  0);
    end
    tick();
    check("t1_level_e4", 32'(level), 1);
    check("t1_rise_e4",  32'(rise),  1);
    tick();
    check("t1_rise_e5",  32'(rise),  0);
    check("t1_pcnt",     32'(press_count), 1);

    // ---- 3: low glitch of 3 edges, then real fall -------------------------
    d_sync = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("t3_glitch_fall",  32'(fall),  0);
      check("t3_glitch_level", 32'(level), 1);
    end
    d_sync = 1'b1;
    tick();
    check("t3_glitch_end", 32'(level), 1);
    d_sync = 1'b0;
    ticks(3);
    check("t3_level_pre", 32'(level), 1);
    tick();
    check("t3_fall_e4",  32'(fall),  1);
    check("t3_level_e4", 32'(level), 0);
    tick();
    check("t3_fall_e5",  32'(fall),  0);
    check("t3_pcnt",     32'(press_count), 1);

    // ---- 2: high glitch of 3 edges after reset, then valid press ----------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    d_sync = 1'b1;
    ticks(3);
    d_sync = 1'b0;
    tick();
    check("t2_glitch_level", 32'(level), 0);
    check("t2_glitch_rise",  32'(rise),  0);
    check("t2_glitch_pcnt",  32'(press_count), 0);
    d_sync = 1'b1;
    ticks(4);
    check("t2_rise",  32'(rise), 1);
    check("t2_pcnt",  32'(press_count), 1);
    d_sync = 1'b0;
    ticks(N);

    // ---- 4: wrap of press_count -------------------------------------------
    for (int p = 1; p < 255; p++) press();
    check("t4_pcnt_255", 32'(press_count), 255);
    press();
    check("t4_pcnt_wrap", 32'(press_count), 0);
    for (int p = 0; p < 7; p++) press();
    check("t4_pcnt_7", 32'(press_count), 7);

    // ---- 5: clr together with accepted rise, then clr alone ---------------
    d_sync = 1'b1;
    ticks(3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_rise",    32'(rise), 1);
    check("t5_clr_rise_pc", 32'(press_count), 0);
    d_sync = 1'b0;
    ticks(N);
    press();
    check("t5_pcnt_1", 32'(press_count), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_alone", 32'(press_count), 0);

    // ---- 6: reset during WAIT_HI -------------------------------------------
    d_sync = 1'b1;
    ticks(2);
    rst_n = 1'b0;
    tick();
    check("t6_rst_level", 32'(level), 0);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("t6_rise_pre", 32'(rise), 0);
      check("t6_level_pre", 32'(level), 0);
    end
    tick();
    check("t6_rise_e4",  32'(rise),  1);
    check("t6_level_e4", 32'(level), 1);
    check("t6_pcnt",     32'(press_count), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
